// File: rtl/cpu_state_machine_pkg.sv
// Shared state and opcode encodings for the control-unit sequencer.
package cpu_pkg;

    typedef logic [5:0] state_t;
    typedef logic [3:0] opcode_t;

    localparam state_t S_IDLE   = 6'd0;
    localparam state_t S_FETCH1 = 6'd1;
    localparam state_t S_FETCH2 = 6'd2;
    localparam state_t S_FETCH3 = 6'd3;
    localparam state_t S_DECODE = 6'd4;
    localparam state_t S_LDAC1  = 6'd8;
    localparam state_t S_LDAC2  = 6'd9;
    localparam state_t S_LDAC3  = 6'd10;
    localparam state_t S_STAC1  = 6'd12;
    localparam state_t S_STAC2  = 6'd13;
    localparam state_t S_STAC3  = 6'd14;
    localparam state_t S_MVAC1  = 6'd16;
    localparam state_t S_ADD1   = 6'd20;
    localparam state_t S_ADD2   = 6'd21;
    localparam state_t S_SUB1   = 6'd24;
    localparam state_t S_SUB2   = 6'd25;
    localparam state_t S_JUMP1  = 6'd28;
    localparam state_t S_JUMP2  = 6'd29;
    localparam state_t S_INC1   = 6'd32;
    localparam state_t S_END    = 6'd62;
    localparam state_t S_TRAP   = 6'd63;

    localparam opcode_t OP_NOP  = 4'd0;
    localparam opcode_t OP_LDAC = 4'd1;
    localparam opcode_t OP_STAC = 4'd2;
    localparam opcode_t OP_MVAC = 4'd3;
    localparam opcode_t OP_ADD  = 4'd4;
    localparam opcode_t OP_SUB  = 4'd5;
    localparam opcode_t OP_JUMP = 4'd6;
    localparam opcode_t OP_INC  = 4'd7;
    localparam opcode_t OP_END  = 4'd15;

endpackage

// File: rtl/cpu_state_machine_if.sv
// Sequencer bus: run request and instruction word in, state code out.
interface cpu_state_machine_if;
    import cpu_pkg::*;

    logic        start;
    logic [15:0] IR;
    state_t      state;

    modport master (output start, output IR, input state);
    modport slave  (input start, input IR, output state);
endinterface

// File: rtl/cpu_state_machine.sv
// Control-unit sequencer: fetch/decode/execute state walk exposed as a 6-bit code.
// Build option: define ILLEGAL_TRAP_EN to send opcodes 8..14 to TRAP instead of NOP.
//
// state        | meaning
// IDLE         | waiting for start
// FETCH1..3    | instruction fetch
// DECODE       | opcode dispatch from IR
// LDAC/STAC*   | three-cycle memory transfer
// MVAC1/INC1   | single-cycle execute
// ADD/SUB/JUMP | two-cycle execute
// END          | halted, waits for start to drop
// TRAP         | illegal opcode, held until reset
module cpu_state_machine
    import cpu_pkg::*;
#(
    parameter int OPCODE_LSB = 0
) (
    input logic               clock,
    input logic               reset,
    cpu_state_machine_if.slave bus
);

    state_t  state_q;
    state_t  state_d;
    opcode_t opcode;
    logic    unused_ir;

    assign opcode    = bus.IR[OPCODE_LSB +: 4];
    assign unused_ir = ^bus.IR;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = bus.start ? S_FETCH1 : S_IDLE;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOP:  state_d = S_FETCH1;
                    OP_LDAC: state_d = S_LDAC1;
                    OP_STAC: state_d = S_STAC1;
                    OP_MVAC: state_d = S_MVAC1;
                    OP_ADD:  state_d = S_ADD1;
                    OP_SUB:  state_d = S_SUB1;
                    OP_JUMP: state_d = S_JUMP1;
                    OP_INC:  state_d = S_INC1;
                    OP_END:  state_d = S_END;
`ifdef ILLEGAL_TRAP_EN
                    default: state_d = S_TRAP;
`else
                    default: state_d = S_FETCH1;
`endif
                endcase
            end
            S_LDAC1:  state_d = S_LDAC2;
            S_LDAC2:  state_d = S_LDAC3;
            S_LDAC3:  state_d = S_FETCH1;
            S_STAC1:  state_d = S_STAC2;
            S_STAC2:  state_d = S_STAC3;
            S_STAC3:  state_d = S_FETCH1;
            S_MVAC1:  state_d = S_FETCH1;
            S_ADD1:   state_d = S_ADD2;
            S_ADD2:   state_d = S_FETCH1;
            S_SUB1:   state_d = S_SUB2;
            S_SUB2:   state_d = S_FETCH1;
            S_JUMP1:  state_d = S_JUMP2;
            S_JUMP2:  state_d = S_FETCH1;
            S_INC1:   state_d = S_FETCH1;
            S_END:    state_d = bus.start ? S_END : S_IDLE;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            // corrupted or unreachable codes recover through IDLE
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.state = state_q;
    end

endmodule

// File: tb/tb_cpu_state_machine.sv
// Self-checking bench for cpu_state_machine: directed plan plus random runs against a queue model.
module tb_cpu_state_machine;

    logic clock = 1'b0;
    logic reset = 1'b1;

    cpu_state_machine_if bus ();

    cpu_state_machine #(.OPCODE_LSB(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // model: current code plus the queue of codes still to come in this instruction
    int m_state = 0;
    int pending[$];

    int  cyc_since_f1 = 0;
    bit  f1_valid = 1'b0;
    bit  op_valid = 1'b0;
    int  last_op = 0;

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int latency_of(int op);
        case (op)
            1, 2:    return 7;
            4, 5, 6: return 6;
            3, 7:    return 5;
            default: return 4;
        endcase
    endfunction

    function automatic void enter_fetch();
        m_state = 1;
        pending.delete();
        pending.push_back(2);
        pending.push_back(3);
        pending.push_back(4);
    endfunction

    function automatic void load_exec(int op);
        pending.delete();
        case (op)
            1: begin pending.push_back(8);  pending.push_back(9);  pending.push_back(10); end
            2: begin pending.push_back(12); pending.push_back(13); pending.push_back(14); end
            3: pending.push_back(16);
            4: begin pending.push_back(20); pending.push_back(21); end
            5: begin pending.push_back(24); pending.push_back(25); end
            6: begin pending.push_back(28); pending.push_back(29); end
            7: pending.push_back(32);
            15: pending.push_back(62);
            0: ;
            default: if (TRAP_EN) pending.push_back(63);
        endcase
    endfunction

    function automatic void model_edge(bit rst, bit st, logic [15:0] ir);
        if (rst) begin
            m_state = 0;
            pending.delete();
        end else begin
            case (m_state)
                0:  if (st) enter_fetch();
                62: if (!st) m_state = 0;
                63: ;
                4: begin
                    load_exec(int'(ir[3:0]));
                    if (pending.size() == 0) enter_fetch();
                    else m_state = pending.pop_front();
                end
                default: begin
                    if (pending.size() > 0) m_state = pending.pop_front();
                    else enter_fetch();
                end
            endcase
        end
    endfunction

    task automatic step(bit rst, bit st, logic [15:0] ir, string tag);
        reset     = rst;
        bus.start = st;
        bus.IR    = ir;
        @(posedge clock);
        if (!rst && m_state == 4) begin
            last_op  = int'(ir[3:0]);
            op_valid = 1'b1;
        end
        model_edge(rst, st, ir);
        #1;
        check(tag, int'(bus.state), m_state);
        cyc_since_f1++;
        if (rst || bus.state == 6'd0 || bus.state == 6'd62 || bus.state == 6'd63) begin
            f1_valid = 1'b0;
            op_valid = 1'b0;
        end else if (bus.state == 6'd1) begin
            if (f1_valid && op_valid)
                check("latency", cyc_since_f1, latency_of(last_op));
            f1_valid     = 1'b1;
            op_valid     = 1'b0;
            cyc_since_f1 = 0;
        end
    endtask

    initial begin
        logic [15:0] ir;
        bit rst, st;
        int ops[6];

        bus.start = 1'b0;
        bus.IR    = 16'd1;

        step(1'b1, 1'b0, 16'd1, "reset");
        step(1'b1, 1'b0, 16'd1, "reset");
        check("reset_zero", int'(bus.state), 0);
        repeat (10) step(1'b0, 1'b0, 16'd1, "idle_hold");

        repeat (9) step(1'b0, 1'b1, 16'd1, "ldac_seq");
        for (int i = 0; i < 20; i++) begin
            if (m_state == 9) break;
            step(1'b0, 1'b1, 16'd1, "ldac_seek9");
        end
        check("reach_state9", int'(bus.state), 9);
        step(1'b1, 1'b1, 16'd1, "reset_mid");
        check("reset_mid_zero", int'(bus.state), 0);

        repeat (10) step(1'b0, 1'b1, 16'd2, "stac_seq");

        ops = '{3, 7, 0, 4, 5, 6};
        foreach (ops[k]) repeat (9) step(1'b0, 1'b1, 16'(ops[k]), "exec_seq");

        // IR wiggles outside DECODE must not disturb the sequence
        repeat (30) begin
            ir = (m_state == 4) ? 16'd4 : 16'($urandom);
            step(1'b0, 1'b1, ir, "ir_noise");
        end

        for (int i = 0; i < 12; i++) begin
            if (m_state == 62) break;
            step(1'b0, 1'b1, 16'h000F, "end_seek");
        end
        check("reach_end", int'(bus.state), 62);
        repeat (5) step(1'b0, 1'b1, 16'h000F, "end_hold");
        step(1'b0, 1'b0, 16'h000F, "end_release");
        check("end_to_idle", int'(bus.state), 0);
        step(1'b0, 1'b1, 16'hF001, "restart");
        check("restart_fetch1", int'(bus.state), 1);
        repeat (10) step(1'b0, 1'b1, 16'hF001, "upper_bits");

        repeat (10) step(1'b0, 1'b1, 16'd8, "illegal_op");
        step(1'b1, 1'b1, 16'd8, "illegal_reset");

        repeat (3000) begin
            rst = ($urandom_range(0, 59) == 0);
            st  = ($urandom_range(0, 9) != 0);
            ir  = 16'($urandom);
            step(rst, st, ir, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
